// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the CPU data port
// and a DMA/loader master. It gives the CPU priority, but a DMA that is denied too
// often in a row is promoted to a bounded burst. It also turns byte addresses into
// word indices and records the first illegal access.
module dmem_arbiter #(
    parameter logic [31:0] ADDR_BASE    = 32'h1001_0000,
    parameter int unsigned DEPTH_LOG2   = 11,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_BURST    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_w,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dma_req,
    input  logic                  dma_w,
    input  logic [31:0]           dma_addr,
    input  logic [31:0]           dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_ack,
    output logic [31:0]           dma_rdata,
    output logic                  mem_ena,
    output logic                  mem_w,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  addr_err,
    output logic [31:0]           err_addr,
    output logic                  err_src
);

    localparam int unsigned WaitW  = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam int unsigned BurstW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [WaitW-1:0]  WaitMax  = WaitW'(STARVE_LIMIT - 1);
    localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST - 1);

    typedef enum logic {
        StCpuPri,
        StDmaBurst
    } state_e;

    state_e              state_q;
    logic [WaitW-1:0]    wait_cnt_q;
    logic [BurstW-1:0]   burst_cnt_q;

    logic                gnt_cpu;
    logic                gnt_dma;
    logic                any_gnt;
    logic                sel_w;
    logic [31:0]         sel_addr;
    logic [31:0]         sel_wdata;
    logic                sel_legal;

    // A byte address is legal when it is word aligned and falls inside the memory window.
    function automatic logic addr_legal(input logic [31:0] addr);
        logic [31:0] offset;
        logic [63:0] word_off;
        offset   = addr - ADDR_BASE;
        word_off = {32'd0, offset} >> 2;
        return (addr >= ADDR_BASE) && (word_off < (64'd1 << DEPTH_LOG2)) &&
               (addr[1:0] == 2'b00);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] addr_index(input logic [31:0] addr);
        logic [31:0] offset;
        offset = addr - ADDR_BASE;
        return DEPTH_LOG2'(offset >> 2);
    endfunction

    // Grant decision: the CPU wins contention unless the DMA has been promoted.
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_dma = 1'b0;
        unique case (state_q)
            StCpuPri: begin
                gnt_cpu = cpu_req;
                gnt_dma = dma_req & ~cpu_req;
            end
            StDmaBurst: begin
                gnt_dma = dma_req;
                gnt_cpu = cpu_req & ~dma_req;
            end
        endcase
    end

    // Route the winning master's access to the memory port.
    always_comb begin
        any_gnt   = gnt_cpu | gnt_dma;
        sel_w     = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt_dma) begin
            sel_w     = dma_w;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
        end else if (gnt_cpu) begin
            sel_w     = cpu_w;
            sel_addr  = cpu_addr;
            sel_wdata = cpu_wdata;
        end
    end

    assign sel_legal = addr_legal(sel_addr);

    // Illegal accesses are still granted but never reach the array; reset blocks all access.
    assign mem_ena   = any_gnt & sel_legal & ~rst;
    assign mem_w     = sel_w & mem_ena;
    assign mem_addr  = any_gnt ? addr_index(sel_addr) : '0;
    assign mem_wdata = any_gnt ? sel_wdata : '0;

    assign cpu_rdata = (gnt_cpu & sel_legal & ~cpu_w) ? mem_rdata : '0;
    assign cpu_stall = cpu_req & ~gnt_cpu;
    assign dma_gnt   = gnt_dma;

    // Arbitration FSM, DMA completion and sticky error capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StCpuPri;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
            dma_ack     <= 1'b0;
            dma_rdata   <= '0;
            addr_err    <= 1'b0;
            err_addr    <= '0;
            err_src     <= 1'b0;
        end else begin
            dma_ack <= gnt_dma;
            if (gnt_dma) begin
                dma_rdata <= (sel_legal & ~dma_w) ? mem_rdata : '0;
            end

            if (any_gnt && !sel_legal && !addr_err) begin
                addr_err <= 1'b1;
                err_addr <= sel_addr;
                err_src  <= gnt_dma;
            end

            unique case (state_q)
                StCpuPri: begin
                    if (cpu_req && dma_req) begin
                        if (wait_cnt_q == WaitMax) begin
                            state_q     <= StDmaBurst;
                            wait_cnt_q  <= '0;
                            burst_cnt_q <= '0;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 1'b1;
                        end
                    end else begin
                        wait_cnt_q <= '0;
                    end
                end
                StDmaBurst: begin
                    if (gnt_dma) begin
                        if (burst_cnt_q == BurstMax) begin
                            state_q     <= StCpuPri;
                            burst_cnt_q <= '0;
                        end else begin
                            burst_cnt_q <= burst_cnt_q + 1'b1;
                        end
                    end else begin
                        // DMA went idle: hand priority straight back to the CPU.
                        state_q     <= StCpuPri;
                        burst_cnt_q <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural model predicts every cycle's
// outputs, and DMA completions are queued and checked by a separate monitor.
module tb_dmem_arbiter;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DLOG  = 11;
    localparam int          DEPTH = 1 << DLOG;
    localparam int          SL    = 4;
    localparam int          MB    = 8;

    logic            clk;
    logic            rst;
    logic            cpu_req, cpu_w, dma_req, dma_w;
    logic [31:0]     cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0]     cpu_rdata, dma_rdata, mem_wdata, mem_rdata, err_addr;
    logic            cpu_stall, dma_gnt, dma_ack, mem_ena, mem_w, addr_err, err_src;
    logic [DLOG-1:0] mem_addr;

    dmem_arbiter #(
        .ADDR_BASE   (BASE),
        .DEPTH_LOG2  (DLOG),
        .STARVE_LIMIT(SL),
        .MAX_BURST   (MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_w    (cpu_w),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dma_req  (dma_req),
        .dma_w    (dma_w),
        .dma_addr (dma_addr),
        .dma_wdata(dma_wdata),
        .dma_gnt  (dma_gnt),
        .dma_ack  (dma_ack),
        .dma_rdata(dma_rdata),
        .mem_ena  (mem_ena),
        .mem_w    (mem_w),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .addr_err (addr_err),
        .err_addr (err_addr),
        .err_src  (err_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // Memory instance stand-in: combinational read, write on the clock edge.
    logic [31:0] mem [DEPTH];
    bit          mem_inited;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
            mem_inited <= 1'b1;
        end else if (mem_ena && mem_w) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    bit          m_dma_pri;
    int          m_losses;
    int          m_left;
    bit          m_err;
    logic [31:0] m_err_addr;
    bit          m_err_src;
    bit          m_last_gd;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ack_t;
    ack_t ack_q[$];

    int n_vec = 0;
    int n_mis = 0;
    bit mon_en = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endfunction

    function automatic bit ref_legal(input logic [31:0] a);
        logic [63:0] off;
        if (a < BASE) return 1'b0;
        if ((a % 4) != 0) return 1'b0;
        off = {32'd0, a} - {32'd0, BASE};
        return (off / 4) < 64'(DEPTH);
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off / 4) % DEPTH);
    endfunction

    task automatic model_reset();
        m_dma_pri  = 1'b0;
        m_losses   = 0;
        m_left     = 0;
        m_err      = 1'b0;
        m_err_addr = '0;
        m_err_src  = 1'b0;
        ack_q.delete();
    endtask

    // Predict this cycle's outputs, compare, then advance the model.
    task automatic model_check();
        bit gc, gd, any, lg, ww;
        logic [31:0] wa, wd, rd;
        int idx;
        if (rst) model_reset();
        gc  = m_dma_pri ? (cpu_req && !dma_req) : cpu_req;
        gd  = m_dma_pri ? dma_req : (dma_req && !cpu_req);
        any = gc || gd;
        wa  = gd ? dma_addr : (gc ? cpu_addr : 32'd0);
        wd  = gd ? dma_wdata : (gc ? cpu_wdata : 32'd0);
        ww  = gd ? dma_w : (gc ? cpu_w : 1'b0);
        lg  = ref_legal(wa);
        idx = ref_idx(wa);
        rd  = ref_mem[idx];
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !gc));
        chk("dma_gnt", 32'(dma_gnt), 32'(gd));
        chk("mem_ena", 32'(mem_ena), 32'(any && lg && !rst));
        chk("mem_w", 32'(mem_w), 32'(any && lg && !rst && ww));
        chk("mem_addr", 32'(mem_addr), any ? 32'(idx) : 32'd0);
        chk("mem_wdata", mem_wdata, wd);
        chk("cpu_rdata", cpu_rdata, (gc && lg && !cpu_w) ? rd : 32'd0);
        chk("addr_err", 32'(addr_err), 32'(m_err));
        chk("err_addr", err_addr, m_err_addr);
        chk("err_src", 32'(err_src), 32'(m_err_src));
        m_last_gd = gd;
        if (rst) return;
        if (gd) ack_q.push_back('{cyc + 1, (lg && !dma_w) ? rd : 32'd0});
        if (any && lg && ww) ref_mem[idx] = wd;
        if (any && !lg && !m_err) begin
            m_err      = 1'b1;
            m_err_addr = wa;
            m_err_src  = gd;
        end
        if (!m_dma_pri) begin
            if (cpu_req && dma_req) begin
                m_losses++;
                if (m_losses == SL) begin
                    m_dma_pri = 1'b1;
                    m_left    = MB;
                    m_losses  = 0;
                end
            end else begin
                m_losses = 0;
            end
        end else if (gd) begin
            m_left--;
            if (m_left == 0) m_dma_pri = 1'b0;
        end else begin
            m_dma_pri = 1'b0;
        end
    endtask

    task automatic step(input bit r, input bit creq, input bit cw, input logic [31:0] ca,
                        input logic [31:0] cd, input bit dreq, input bit dw,
                        input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        rst       = r;
        cpu_req   = creq;
        cpu_w     = cw;
        cpu_addr  = ca;
        cpu_wdata = cd;
        dma_req   = dreq;
        dma_w     = dw;
        dma_addr  = da;
        dma_wdata = dd;
        @(negedge clk);
        model_check();
    endtask

    // Completion monitor: every DMA grant must be followed by exactly one ack.
    always @(negedge clk) begin
        bit          exp_ack;
        logic [31:0] exp_d;
        if (mon_en) begin
            exp_ack = 1'b0;
            exp_d   = '0;
            if (!rst && ack_q.size() > 0 && ack_q[0].due == cyc) begin
                exp_ack = 1'b1;
                exp_d   = ack_q[0].data;
                void'(ack_q.pop_front());
            end
            chk("dma_ack", 32'(dma_ack), 32'(exp_ack));
            if (exp_ack) chk("dma_rdata", dma_rdata, exp_d);
        end
    end

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 31);
        case (r)
            0:       return BASE - 32'd4;
            1:       return BASE + 32'(DEPTH * 4);
            2:       return BASE + 32'h11;
            3:       return BASE + 32'(DEPTH * 4 - 4);
            default: return BASE + 32'($urandom_range(0, 15) * 4);
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_w = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_w = 0; dma_addr = 0; dma_wdata = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        model_reset();
        m_last_gd = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("rst_dma_rdata", dma_rdata, 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_mem_ena", 32'(mem_ena), 32'd0);
        mon_en = 1'b1;

        // CPU alone reads word 2.
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 32'h1001_0008, 0, 0, 0, 0, 0);
            chk("cpu_rd_addr", 32'(mem_addr), 32'd2);
            chk("cpu_rd_data", cpu_rdata, init_word(2));
        end

        // DMA alone writes, then the CPU reads it back.
        step(0, 0, 0, 0, 0, 1, 1, 32'h1001_0010, 32'hDEAD_BEEF);
        chk("dma_wr_gnt", 32'(dma_gnt), 32'd1);
        chk("dma_wr_addr", 32'(mem_addr), 32'd4);
        step(0, 1, 0, 32'h1001_0010, 0, 0, 0, 0, 0);
        chk("dma_wr_ack", 32'(dma_ack), 32'd1);
        chk("dma_rdback", cpu_rdata, 32'hDEAD_BEEF);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("dma_ack_once", 32'(dma_ack), 32'd0);

        // Continuous contention: 4 CPU cycles then an 8-grant DMA burst, repeating.
        for (int k = 0; k < 24; k++) begin
            step(0, 1, 0, BASE + 32'(4 * (k % 8)), 0, 1, 0, BASE + 32'h40, 0);
            chk("pattern_gnt", 32'(dma_gnt), 32'((k % 12) >= 4));
            chk("pattern_stall", 32'(cpu_stall), 32'((k % 12) >= 4));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // DMA drops out after 3 burst grants; the CPU is served the same cycle.
        for (int k = 0; k < 7; k++) step(0, 1, 0, BASE, 0, 1, 0, BASE + 32'h20, 0);
        step(0, 1, 0, BASE + 32'h4, 0, 0, 0, 0, 0);
        chk("drop_stall", 32'(cpu_stall), 32'd0);
        step(0, 1, 0, BASE + 32'h8, 0, 1, 0, BASE + 32'h20, 0);
        chk("drop_cpu_first", 32'(cpu_stall), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Illegal accesses: first error sticks.
        step(0, 1, 1, 32'h1000_FFFC, 32'h1111_1111, 0, 0, 0, 0);
        chk("ill_cpu_ena", 32'(mem_ena), 32'd0);
        chk("ill_cpu_stall", 32'(cpu_stall), 32'd0);
        step(0, 0, 0, 0, 0, 1, 1, 32'h1001_2000, 32'h2222_2222);
        chk("ill_dma_ena", 32'(mem_ena), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ill_flag", 32'(addr_err), 32'd1);
        chk("ill_addr", err_addr, 32'h1000_FFFC);
        chk("ill_src", 32'(err_src), 32'd0);

        // Reset during burst cycle 5 with a DMA write pending.
        for (int k = 0; k < 8; k++) step(0, 1, 0, BASE, 0, 1, 0, BASE + 32'h44, 0);
        step(1, 1, 0, BASE + 32'h40, 0, 1, 1, BASE + 32'h40, 32'h1234_5678);
        chk("rstb_ena", 32'(mem_ena), 32'd0);
        chk("rstb_w", 32'(mem_w), 32'd0);
        chk("rstb_ack", 32'(dma_ack), 32'd0);
        chk("rstb_err", 32'(addr_err), 32'd0);
        chk("rstb_rdata", dma_rdata, 32'd0);
        step(1, 1, 0, BASE + 32'h40, 0, 1, 1, BASE + 32'h40, 32'h1234_5678);
        step(0, 1, 0, BASE + 32'h40, 0, 1, 1, BASE + 32'h40, 32'h1234_5678);
        chk("rstb_cpu_first", 32'(cpu_stall), 32'd0);
        chk("rstb_no_write", cpu_rdata, init_word(16));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic; DMA holds its request until granted.
        for (int k = 0; k < 600; k++) begin
            bit          creq, cw, dreq, dw;
            logic [31:0] ca, cd, da, dd;
            creq = ($urandom_range(0, 99) < 60);
            cw   = $urandom_range(0, 1) == 1;
            ca   = rand_addr();
            cd   = $urandom;
            if (!dma_req || m_last_gd) begin
                dreq = ($urandom_range(0, 99) < 55);
                dw   = $urandom_range(0, 1) == 1;
                da   = rand_addr();
                dd   = $urandom;
            end else begin
                dreq = dma_req;
                dw   = dma_w;
                da   = dma_addr;
                dd   = dma_wdata;
            end
            step(0, creq, cw, ca, cd, dreq, dw, da, dd);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the single-cycle CPU data port and a second master (DMA/loader) and translates byte addresses into memory word indices. Sits between cpu/DMA and the memory instance in the top-level dataflow. Drives the CPU stall input whenever the CPU loses arbitration. Starvation-limited CPU priority with bounded DMA bursts.

Parameters:
ADDR_BASE, 32'h10010000, byte address of memory word 0
DEPTH_LOG2, 11, word-index width; memory holds 2^DEPTH_LOG2 words
STARVE_LIMIT, 4, consecutive contested DMA denials before DMA is promoted (>=1)
MAX_BURST, 8, max consecutive DMA grants while promoted (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU data access request (DM_ena)
cpu_w  in  1  CPU write enable
cpu_addr  in  32  CPU byte address
cpu_wdata  in  32  CPU write data
cpu_rdata  out  32  CPU read data, combinational
cpu_stall  out  1  stall to CPU, combinational
dma_req  in  1  DMA request; held with dma_w/addr/wdata stable until dma_gnt
dma_w  in  1  DMA write enable
dma_addr  in  32  DMA byte address
dma_wdata  in  32  DMA write data
dma_gnt  out  1  DMA access performed this cycle, combinational
dma_ack  out  1  registered pulse, cycle after each DMA grant
dma_rdata  out  32  registered read data, valid with dma_ack
mem_ena  out  1  memory enable
mem_w  out  1  memory write enable
mem_addr  out  DEPTH_LOG2  memory word index
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, combinational
addr_err  out  1  sticky illegal-address flag
err_addr  out  32  byte address of first illegal access
err_src  out  1  source of first error: 0 CPU, 1 DMA

Behaviour:
- Reset (async, immediate): state=CPU_PRI, wait_cnt=0, burst_cnt=0, dma_ack=0, dma_rdata=0, addr_err=0, err_addr=0, err_src=0. Combinational outputs follow inputs with these state values. Reset mid-burst aborts the burst; no memory write occurs while rst=1 (mem_ena forced 0).
- Grant, combinational each cycle:
  - CPU_PRI: gnt_cpu=cpu_req; gnt_dma=dma_req & ~cpu_req.
  - DMA_BURST: gnt_dma=dma_req; gnt_cpu=cpu_req & ~dma_req.
  - cpu_stall=cpu_req & ~gnt_cpu; dma_gnt=gnt_dma.
- Mux: winner's w/addr/wdata drive memory. mem_ena=gnt & legal; mem_w=winner_w & mem_ena. No grant -> mem_ena=0, mem_w=0, mem_addr=0, mem_wdata=0.
- Translation: offset=addr-ADDR_BASE (32-bit); mem_addr=offset[DEPTH_LOG2+1:2]. Legal iff addr>=ADDR_BASE, offset>>2 < 2^DEPTH_LOG2, addr[1:0]==0.
- cpu_rdata=mem_rdata when gnt_cpu & legal & ~cpu_w, else 0.
- DMA completion: on each edge with gnt_dma, dma_ack<=1 and dma_rdata<=(legal & ~dma_w) ? mem_rdata : 0. Otherwise dma_ack<=0 and dma_rdata holds. The DMA may present its next request in the cycle after the grant, so back-to-back grants are allowed.
- Illegal access: the access is still granted and completes (no stall), with no memory effect. If addr_err==0: addr_err<=1, err_addr<=addr, err_src<=source. Later errors do not overwrite. Cleared only by reset.
- FSM (registered):
  - CPU_PRI:
    - Contested cycle (cpu_req & dma_req): if wait_cnt==STARVE_LIMIT-1 -> DMA_BURST, wait_cnt<=0, burst_cnt<=0; else wait_cnt++.
    - DMA granted, or dma_req=0: wait_cnt<=0.
  - DMA_BURST:
    - Each DMA grant: burst_cnt++. If burst_cnt==MAX_BURST-1 -> CPU_PRI, burst_cnt<=0.
    - dma_req=0 -> CPU_PRI, burst_cnt<=0 (CPU may be granted the same cycle).
- The CPU never waits more than MAX_BURST cycles. DMA is granted no later than the (STARVE_LIMIT+1)th contested cycle.
- Counter widths: wait_cnt and burst_cnt sized to their limits; never wrap.

Test Plan:
- Reset release, CPU alone reads 0x10010008 -> mem_addr=2, mem_ena=1, mem_w=0, cpu_rdata=mem_rdata, cpu_stall=0 every cycle; dma_ack=0.
- DMA alone writes 0xDEADBEEF to 0x10010010 -> dma_gnt same cycle, mem_addr=4, mem_w=1; dma_ack=1 next cycle only.
- Both request continuously (defaults) -> CPU granted cycles 0–3, DMA granted cycles 4–11 with cpu_stall=1, CPU granted cycle 12; pattern repeats.
- DMA drops dma_req after 3 burst grants -> FSM returns to CPU_PRI; a CPU request that same cycle is granted with cpu_stall=0.
- CPU writes 0x1000FFFC, then DMA writes 0x10012000 -> mem_ena=0 for both, no stalls; addr_err=1, err_addr=0x1000FFFC, err_src=0 (not overwritten).
- Assert rst during cycle 5 of a DMA burst with a write pending -> no write, state CPU_PRI, dma_ack=0, addr_err=0; after release, CPU granted first on contention.
